// File: rtl/apb_reg_slave.sv
// APB completer with a bank of RW registers, one read-only status word,
// configurable wait states and pslverr for out-of-range or read-only writes.
module apb_reg_slave #(
    parameter int                AWIDTH      = 4,
    parameter int                DWIDTH      = 8,
    parameter int                NUM_REGS    = 12,
    parameter int                WAIT_STATES = 0,
    parameter logic [DWIDTH-1:0] RESET_VAL   = '0
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [AWIDTH-1:0] paddr,
    input  logic [DWIDTH-1:0] pwdata,
    output logic [DWIDTH-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [DWIDTH-1:0] status_in,
    output logic [DWIDTH-1:0] ctrl_out
);

    localparam logic [0:0]        IDLE        = 1'b0;
    localparam logic [0:0]        ACCESS      = 1'b1;
    localparam logic [AWIDTH-1:0] STATUS_ADDR = AWIDTH'(NUM_REGS);
    localparam logic [3:0]        WAIT_LAST   = 4'(WAIT_STATES);

    logic [0:0]        state;
    logic [3:0]        wait_cnt;
    logic [AWIDTH-1:0] addr_q;
    logic              write_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] regs [NUM_REGS];
    logic [DWIDTH-1:0] rd_val;
    logic              commit;

    // Read mux works on the live bus address because prdata is loaded at the setup edge.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps the block latch-free.
        rd_val = '0;
        if (paddr < STATUS_ADDR) begin
            rd_val = regs[paddr];
        end else if (paddr == STATUS_ADDR) begin
            rd_val = status_in;
        end
    end

    assign pready   = (state == ACCESS) && (wait_cnt == WAIT_LAST);
    assign pslverr  = pready && ((addr_q > STATUS_ADDR) || (write_q && (addr_q == STATUS_ADDR)));
    assign commit   = pready && psel && penable && write_q && (addr_q < STATUS_ADDR);
    assign ctrl_out = regs[0];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            prdata   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state    <= ACCESS;
                        addr_q   <= paddr;
                        write_q  <= pwrite;
                        wdata_q  <= pwdata;
                        wait_cnt <= '0;
                        if (!pwrite) begin
                            prdata <= rd_val;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (penable) begin
                        if (pready) begin
                            state <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            // NOTE: the register bank is a handful of flops, not RAM, so it is safe to reset in a loop.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (commit) begin
            regs[addr_q] <= wdata_q;
        end
    end

endmodule
